sdram_frame_arbiter: RTL and testbench

//  Shares the single-page-burst SDRAM controller between the camera write path and the display read path.

---
 rtl/sdram_pkg.sv | 24 ++
 rtl/frame_page_ptr.sv | 56 +++++
 rtl/sdram_frame_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sdram_frame_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared constants and encodings for the SDRAM frame arbiter.
// Sizes follow a 640x480x16b frame split into 512-word pages.
package sdram_pkg;

  localparam int PAGE_WORDS  = 512;
  localparam int FRAME_PAGES = 600;
  localparam int MAX_RD_RUN  = 4;
  localparam int TIMEOUT     = 4096;
  localparam int LVL_W       = 11;
  localparam int ADDR_W      = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_DONE
  } state_e;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_e;

endpackage

// File: rtl/frame_page_ptr.sv
// Wrapping page pointer with an immediate zero and a deferred
// zero that takes effect when the in-flight burst completes.
module frame_page_ptr #(
  parameter int PAGES = sdram_pkg::FRAME_PAGES,
  parameter int PW    = $clog2(PAGES)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_zero,
  input  logic          i_pend_set,
  input  logic          i_adv,
  input  logic          i_abort,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          pend_q, pend_d;
  logic          pend_any;

  always_comb begin
    pend_any = pend_q | i_pend_set;
    ptr_d    = ptr_q;
    pend_d   = pend_any;
    if (i_zero) begin
      ptr_d = '0;
    end
    // A frame start seen during the burst wins over the advance
    if (i_adv) begin
      pend_d = 1'b0;
      if (pend_any || ptr_q == PW'(PAGES - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
    if (i_abort) begin
      pend_d = 1'b0;
      if (pend_any) begin
        ptr_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      ptr_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      pend_q <= pend_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Arbitrates single-page SDRAM bursts between camera writes and
// display reads, and streams burst data to/from the FIFOs.
module sdram_frame_arbiter #(
  parameter int PAGE_WORDS  = sdram_pkg::PAGE_WORDS,
  parameter int FRAME_PAGES = sdram_pkg::FRAME_PAGES,
  parameter int MAX_RD_RUN  = sdram_pkg::MAX_RD_RUN,
  parameter int TIMEOUT     = sdram_pkg::TIMEOUT,
  parameter int LVL_W       = sdram_pkg::LVL_W
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_wr_frame_start,
  input  logic             i_rd_frame_start,
  input  logic [LVL_W-1:0] i_wr_fifo_level,
  input  logic [15:0]      i_wr_fifo_data,
  output logic             o_wr_fifo_pop,
  input  logic [LVL_W-1:0] i_rd_fifo_free,
  output logic             o_rd_fifo_push,
  output logic [15:0]      o_rd_fifo_data,
  input  logic             i_sd_ready,
  output logic             o_sd_en,
  output logic             o_sd_rw,
  output logic [14:0]      o_sd_addr,
  output logic [15:0]      o_sd_datain,
  input  logic [15:0]      i_sd_dataout,
  input  logic             i_sd_dataval,
  input  logic             i_sd_is_writing,
  output logic             o_busy,
  output logic             o_err
);

  import sdram_pkg::*;

  localparam int PW = $clog2(FRAME_PAGES);
  localparam int RW = $clog2(MAX_RD_RUN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e      state_q, state_d;
  dir_e        dir_q, dir_d;
  logic [RW-1:0] run_q, run_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [14:0] addr_q, addr_d;
  logic        err_q, err_d;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_base, rd_base;
  logic        wr_ok, rd_ok, rd_pick;
  logic        is_rd, strobe, busy, xfer_ph;
  logic        wr_fly, rd_fly;
  logic        done, abort;

  assign wr_ok   = i_wr_fifo_level >= LVL_W'(PAGE_WORDS);
  assign rd_ok   = i_rd_fifo_free >= LVL_W'(PAGE_WORDS);
  assign rd_pick = rd_ok && !(wr_ok && run_q == RW'(MAX_RD_RUN));

  assign is_rd   = (dir_q == DIR_RD);
  assign strobe  = is_rd ? i_sd_dataval : i_sd_is_writing;
  assign busy    = (state_q != ST_IDLE);
  assign xfer_ph = (state_q == ST_ISSUE) || (state_q == ST_XFER);
  assign wr_fly  = busy && !is_rd;
  assign rd_fly  = busy && is_rd;

  // A frame start on the granting cycle already selects page 0
  assign wr_base = i_wr_frame_start ? '0 : wr_ptr;
  assign rd_base = i_rd_frame_start ? '0 : rd_ptr;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    run_d   = run_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    err_d   = err_q;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (i_sd_ready && (rd_ok || wr_ok)) begin
          state_d = ST_ISSUE;
          if (rd_pick) begin
            dir_d  = DIR_RD;
            run_d  = wr_ok ? run_q + 1'b1 : '0;
            addr_d = 15'(rd_base);
          end else begin
            dir_d  = DIR_WR;
            run_d  = '0;
            addr_d = 15'(wr_base);
          end
        end
      end
      ST_ISSUE: begin
        if (strobe) begin
          state_d = ST_XFER;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          abort   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_XFER: begin
        if (!strobe) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_WR;
      run_q   <= '0;
      tmo_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      run_q   <= run_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  frame_page_ptr #(
    .PAGES (FRAME_PAGES),
    .PW    (PW)
  ) u_wr_ptr (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_zero     (i_wr_frame_start && !wr_fly),
    .i_pend_set (i_wr_frame_start && wr_fly),
    .i_adv      (done && !is_rd),
    .i_abort    (abort && !is_rd),
    .o_ptr      (wr_ptr)
  );

  frame_page_ptr #(
    .PAGES (FRAME_PAGES),
    .PW    (PW)
  ) u_rd_ptr (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_zero     (i_rd_frame_start && !rd_fly),
    .i_pend_set (i_rd_frame_start && rd_fly),
    .i_adv      (done && is_rd),
    .i_abort    (abort && is_rd),
    .o_ptr      (rd_ptr)
  );

  // Request drops on the first beat so the controller sees one burst
  assign o_sd_en        = (state_q == ST_ISSUE) && !strobe;
  assign o_sd_rw        = dir_q;
  assign o_sd_addr      = addr_q;
  assign o_rd_fifo_push = xfer_ph && is_rd && i_sd_dataval;
  assign o_rd_fifo_data = o_rd_fifo_push ? i_sd_dataout : '0;
  assign o_wr_fifo_pop  = xfer_ph && !is_rd && i_sd_is_writing;
  assign o_sd_datain    = (xfer_ph && !is_rd) ? i_wr_fifo_data : '0;
  assign o_busy         = busy;
  assign o_err          = err_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Bench for sdram_frame_arbiter: controller model, page/grant
// reference model, eligibility table and burst sequences.
module tb_sdram_frame_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_wr_frame_start = 1'b0;
  logic        i_rd_frame_start = 1'b0;
  logic [10:0] i_wr_fifo_level = '0;
  logic [15:0] i_wr_fifo_data = '0;
  logic        o_wr_fifo_pop;
  logic [10:0] i_rd_fifo_free = '0;
  logic        o_rd_fifo_push;
  logic [15:0] o_rd_fifo_data;
  logic        i_sd_ready = 1'b1;
  logic        o_sd_en;
  logic        o_sd_rw;
  logic [14:0] o_sd_addr;
  logic [15:0] o_sd_datain;
  logic [15:0] i_sd_dataout = '0;
  logic        i_sd_dataval = 1'b0;
  logic        i_sd_is_writing = 1'b0;
  logic        o_busy;
  logic        o_err;

  always #5 i_clk = ~i_clk;

  sdram_frame_arbiter dut (
    .i_clk            (i_clk),
    .i_rstn           (i_rstn),
    .i_wr_frame_start (i_wr_frame_start),
    .i_rd_frame_start (i_rd_frame_start),
    .i_wr_fifo_level  (i_wr_fifo_level),
    .i_wr_fifo_data   (i_wr_fifo_data),
    .o_wr_fifo_pop    (o_wr_fifo_pop),
    .i_rd_fifo_free   (i_rd_fifo_free),
    .o_rd_fifo_push   (o_rd_fifo_push),
    .o_rd_fifo_data   (o_rd_fifo_data),
    .i_sd_ready       (i_sd_ready),
    .o_sd_en          (o_sd_en),
    .o_sd_rw          (o_sd_rw),
    .o_sd_addr        (o_sd_addr),
    .o_sd_datain      (o_sd_datain),
    .i_sd_dataout     (i_sd_dataout),
    .i_sd_dataval     (i_sd_dataval),
    .i_sd_is_writing  (i_sd_is_writing),
    .o_busy           (o_busy),
    .o_err            (o_err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference model state
  int m_wr, m_rd, m_run, m_addr;
  bit m_pwr, m_prd, m_fly, m_cur_rd;
  int beats_push, beats_pop, en_cyc, push_total;
  int done_cnt = 0;
  int last_addr, last_rd;
  bit [31:0] grants;
  bit en_q, busy_q, err_q;
  bit p_wok, p_rok;

  // controller model
  bit ctl_on = 1'b1;
  int c_dly = 20;
  int c_nb = 512;
  int c_wait, c_beat, c_addr;
  bit c_act;

  task automatic model_clear();
    m_wr = 0; m_rd = 0; m_run = 0;
    m_pwr = 0; m_prd = 0;
    push_total = 0; grants = '0;
  endtask

  always @(negedge i_clk) begin
    if (!i_rstn) begin
      m_fly = 0; en_q = 0; busy_q = 0; err_q = 0;
      c_act = 0; c_wait = 0;
      i_sd_dataval = 0; i_sd_is_writing = 0;
    end else begin
      if (o_sd_en && !en_q) begin
        p_wok = i_wr_fifo_level >= 512;
        p_rok = i_rd_fifo_free >= 512;
        if (p_rok && !(p_wok && m_run == 4)) begin
          m_cur_rd = 1; m_run = p_wok ? m_run + 1 : 0; m_addr = m_rd;
        end else begin
          m_cur_rd = 0; m_run = 0; m_addr = m_wr;
        end
        chk("issue_rw", o_sd_rw, m_cur_rd);
        chk("issue_addr", o_sd_addr, m_addr);
        m_fly = 1; beats_push = 0; beats_pop = 0; en_cyc = 0;
        grants = {grants[30:0], o_sd_rw};
      end
      if (o_sd_en) en_cyc++;
      if (o_rd_fifo_push) begin
        chk("rd_data", o_rd_fifo_data,
            ((m_addr % 128) << 9) | (beats_push % 512));
        beats_push++; push_total++;
      end
      if (o_wr_fifo_pop) begin
        chk("wr_data", o_sd_datain, i_wr_fifo_data);
        beats_pop++;
      end
      if (busy_q && !o_busy) begin
        if (o_err && !err_q) begin
          chk("tmo_cycles", en_cyc, 4096);
          chk("tmo_beats", beats_push + beats_pop, 0);
          if (m_cur_rd && m_prd) m_rd = 0;
          if (!m_cur_rd && m_pwr) m_wr = 0;
        end else begin
          chk("beats_push", beats_push, m_cur_rd ? c_nb : 0);
          chk("beats_pop", beats_pop, m_cur_rd ? 0 : c_nb);
          if (m_cur_rd) m_rd = m_prd ? 0 : (m_rd + 1) % 600;
          else          m_wr = m_pwr ? 0 : (m_wr + 1) % 600;
        end
        if (m_cur_rd) m_prd = 0; else m_pwr = 0;
        m_fly = 0; last_addr = m_addr; last_rd = m_cur_rd;
        done_cnt++;
      end
      en_q = o_sd_en; busy_q = o_busy; err_q = o_err;
      // controller: start c_dly cycles after request, c_nb beats
      if (c_act) begin
        c_beat++;
        if (c_beat == c_nb) begin
          c_act = 0; i_sd_dataval = 0; i_sd_is_writing = 0;
        end
      end else if (o_sd_en && ctl_on) begin
        c_wait++;
        if (c_wait >= c_dly) begin
          c_act = 1; c_beat = 0; c_wait = 0;
          c_addr = int'(o_sd_addr);
          if (o_sd_rw) i_sd_dataval = 1; else i_sd_is_writing = 1;
        end
      end else begin
        c_wait = 0;
      end
      i_sd_dataout = 16'(((c_addr % 128) << 9) | (c_beat % 512));
      i_wr_fifo_data = 16'($urandom);
    end
  end

  task automatic do_reset();
    @(negedge i_clk); #1;
    i_rstn = 0;
    i_wr_fifo_level = '0; i_rd_fifo_free = '0;
    i_wr_frame_start = 0; i_rd_frame_start = 0;
    @(negedge i_clk); #1;
    chk("reset_outs", {o_sd_en, o_sd_rw, o_sd_addr, o_sd_datain,
        o_rd_fifo_push, o_rd_fifo_data, o_wr_fifo_pop, o_busy, o_err}, 0);
    model_clear();
    @(negedge i_clk); #1;
    i_rstn = 1;
  endtask

  task automatic wait_busy(input string nm);
    int b = 200;
    while (!o_busy && b > 0) begin
      @(negedge i_clk); #1;
      b--;
    end
    if (!o_busy) chk({nm, "_busy_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input int target, input int budget, input string nm);
    int b = budget;
    while (done_cnt < target && b > 0) begin
      @(negedge i_clk); #1;
      b--;
    end
    if (done_cnt < target) chk({nm, "_done_timeout"}, done_cnt, target);
  endtask

  task automatic pulse_fs(input bit w, input bit r);
    if (w) begin
      if (m_fly && !m_cur_rd) m_pwr = 1; else m_wr = 0;
    end
    if (r) begin
      if (m_fly && m_cur_rd) m_prd = 1; else m_rd = 0;
    end
    i_wr_frame_start = w; i_rd_frame_start = r;
    @(negedge i_clk); #1;
    i_wr_frame_start = 0; i_rd_frame_start = 0;
  endtask

  typedef struct {
    int wl;
    int rf;
    bit en;
    bit rw;
  } vec_t;

  vec_t tbl[7];
  int d0;
  bit saw;

  initial begin
    tbl[0] = '{511, 511, 1'b0, 1'b0};
    tbl[1] = '{512, 0, 1'b1, 1'b0};
    tbl[2] = '{0, 512, 1'b1, 1'b1};
    tbl[3] = '{511, 512, 1'b1, 1'b1};
    tbl[4] = '{512, 511, 1'b1, 1'b0};
    tbl[5] = '{2047, 2047, 1'b1, 1'b1};
    tbl[6] = '{0, 2047, 1'b1, 1'b1};

    // eligibility thresholds, controller silent
    ctl_on = 0;
    for (int i = 0; i < 7; i++) begin
      do_reset();
      i_wr_fifo_level = 11'(tbl[i].wl);
      i_rd_fifo_free = 11'(tbl[i].rf);
      repeat (10) @(negedge i_clk);
      #1;
      chk("tbl_en", o_sd_en, tbl[i].en);
      chk("tbl_busy", o_busy, tbl[i].en);
      chk("tbl_rw", o_sd_rw, tbl[i].rw);
      chk("tbl_addr", o_sd_addr, 0);
    end
    ctl_on = 1;

    // 1: no request until controller ready
    do_reset();
    i_sd_ready = 0;
    i_wr_fifo_level = 600;
    saw = 0;
    repeat (50) begin
      @(negedge i_clk); #1;
      if (o_sd_en) saw = 1;
    end
    chk("noready_en", saw, 0);
    d0 = done_cnt;
    i_sd_ready = 1;
    wait_busy("t1a");
    i_wr_fifo_level = 0;
    wait_done(d0 + 1, 700, "t1a");
    chk("t1_addr", last_addr, 0);
    chk("t1_rd", last_rd, 0);
    i_wr_fifo_level = 600;
    wait_busy("t1b");
    i_wr_fifo_level = 0;
    wait_done(d0 + 2, 700, "t1b");
    chk("t1_addr2", last_addr, 1);

    // 2: three reads back to back
    do_reset();
    d0 = done_cnt;
    i_rd_fifo_free = 1024;
    wait_done(d0 + 3, 2000, "t2");
    i_rd_fifo_free = 0;
    chk("t2_addr", last_addr, 2);
    chk("t2_pushes", push_total, 1536);

    // 3: both eligible -> R R R R W pattern
    do_reset();
    d0 = done_cnt;
    i_wr_fifo_level = 1024; i_rd_fifo_free = 1024;
    wait_done(d0 + 10, 6000, "t3");
    i_wr_fifo_level = 0; i_rd_fifo_free = 0;
    chk("t3_grants", grants[9:0], 10'b1111011110);

    // 4: wrap at 599, then frame start during a write
    do_reset();
    d0 = done_cnt;
    c_dly = 1; c_nb = 1;
    i_wr_fifo_level = 600;
    wait_done(d0 + 600, 600 * 12, "t4a");
    chk("t4_addr599", last_addr, 599);
    wait_done(d0 + 601, 20, "t4b");
    chk("t4_wrap", last_addr, 0);
    i_wr_fifo_level = 0;
    c_dly = 20; c_nb = 512;
    i_wr_fifo_level = 600;
    wait_busy("t4c");
    i_wr_fifo_level = 0;
    repeat (100) @(negedge i_clk);
    #1;
    pulse_fs(1, 0);
    wait_done(d0 + 602, 700, "t4c");
    chk("t4_addr1", last_addr, 1);
    i_wr_fifo_level = 600;
    wait_busy("t4d");
    i_wr_fifo_level = 0;
    wait_done(d0 + 603, 700, "t4d");
    chk("t4_fs_zero", last_addr, 0);

    // 5: start timeout
    do_reset();
    d0 = done_cnt;
    ctl_on = 0;
    i_wr_fifo_level = 600;
    wait_busy("t5");
    i_wr_fifo_level = 0;
    wait_done(d0 + 1, 4300, "t5");
    chk("t5_err", o_err, 1);
    chk("t5_en", o_sd_en, 0);
    chk("t5_busy", o_busy, 0);
    repeat (20) @(negedge i_clk);
    #1;
    chk("t5_err_sticky", o_err, 1);
    ctl_on = 1;
    do_reset();
    chk("t5_err_clr", o_err, 0);

    // 6: reset in the middle of a read transfer
    d0 = done_cnt;
    i_rd_fifo_free = 1024;
    wait_done(d0 + 2, 1400, "t6a");
    wait_busy("t6b");
    repeat (120) @(negedge i_clk);
    #1;
    do_reset();
    d0 = done_cnt;
    i_rd_fifo_free = 1024;
    wait_busy("t6c");
    i_rd_fifo_free = 0;
    wait_done(d0 + 1, 700, "t6c");
    chk("t6_addr", last_addr, 0);
    chk("t6_rd", last_rd, 1);

    // random levels and frame starts against the model
    do_reset();
    for (int k = 0; k < 12; k++) begin
      int wl, rf;
      d0 = done_cnt;
      wl = $urandom_range(0, 2047);
      rf = $urandom_range(0, 2047);
      if (wl < 512 && rf < 512) wl = 512 + $urandom_range(0, 1000);
      i_wr_fifo_level = 11'(wl);
      i_rd_fifo_free = 11'(rf);
      wait_busy("rnd");
      i_wr_fifo_level = 0; i_rd_fifo_free = 0;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 500)) @(negedge i_clk);
        #1;
        pulse_fs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      wait_done(d0 + 1, 700, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
